// File: rtl/cnt_monitor_if.sv
// Sample stream into the counter monitor and the status it reports back.
interface cnt_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
);
  logic              cnt_valid;
  logic [WIDTH-1:0]  cnt;
  logic              clr;
  logic              locked;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              wrap_pulse;
  logic [WIDTH-1:0]  last_cnt;

  modport master (
    output cnt_valid, cnt, clr,
    input  locked, err, err_cnt, wrap_cnt, wrap_pulse, last_cnt
  );
  modport slave (
    input  cnt_valid, cnt, clr,
    output locked, err, err_cnt, wrap_cnt, wrap_pulse, last_cnt
  );
endinterface

// File: rtl/cnt_monitor.sv
// Checks a free-running counter stream for +1 steps, counts wraps and
// sequence errors, and resyncs after a jump once RELOCK good steps are seen.
module cnt_monitor #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4,
  parameter int RELOCK = 2
) (
  input logic          clk,
  input logic          rst_n,
  cnt_monitor_if.slave bus
);
  typedef enum logic [1:0] {SYNC, TRACK, RESYNC} state_t;

  state_t            state;
  logic [3:0]        run;
  logic              locked, err, wrap_pulse;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WIDTH-1:0]  last_cnt;
  logic              step_good, at_max;

  assign step_good = (bus.cnt == WIDTH'(last_cnt + 1'b1));
  assign at_max    = (last_cnt == {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SYNC;
      run        <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
      wrap_pulse <= 1'b0;
      last_cnt   <= '0;
    end else if (bus.clr) begin
      state      <= SYNC;
      run        <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
      wrap_pulse <= 1'b0;
      last_cnt   <= '0;
    end else begin
      wrap_pulse <= 1'b0;
      if (bus.cnt_valid) begin
        last_cnt <= bus.cnt;
        unique case (state)
          SYNC: begin
            state  <= TRACK;
            locked <= 1'b1;
          end
          TRACK: begin
            if (step_good) begin
              if (at_max) begin
                wrap_cnt   <= wrap_cnt + 1'b1;
                wrap_pulse <= 1'b1;
              end
            end else begin
              err    <= 1'b1;
              if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
              run    <= '0;
              state  <= RESYNC;
              locked <= 1'b0;
            end
          end
          RESYNC: begin
            // wraps seen while resyncing are deliberately not counted
            if (step_good) begin
              if (run == 4'(RELOCK - 1)) begin
                run    <= '0;
                state  <= TRACK;
                locked <= 1'b1;
              end else begin
                run <= run + 1'b1;
              end
            end else begin
              if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
              run <= '0;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  assign bus.locked     = locked;
  assign bus.err        = err;
  assign bus.err_cnt    = err_cnt;
  assign bus.wrap_cnt   = wrap_cnt;
  assign bus.wrap_pulse = wrap_pulse;
  assign bus.last_cnt   = last_cnt;
endmodule

// File: tb/tb_cnt_monitor.sv
// Scoreboard bench for cnt_monitor: a reference model queues the expected
// status per driven cycle, compared one cycle later on the falling edge.
module tb_cnt_monitor;
  localparam int WIDTH = 4, WRAP_W = 8, ERR_W = 4, RELOCK = 2;

  typedef struct {
    logic              locked, err, wrap_pulse;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [WIDTH-1:0]  last_cnt;
  } exp_t;

  logic gclk, rst_n;
  int   checks = 0, errors = 0;
  exp_t sb[$];

  // model state
  int                m_state, m_run;
  logic              m_locked, m_err, m_pulse;
  logic [ERR_W-1:0]  m_errc;
  logic [WRAP_W-1:0] m_wrap;
  logic [WIDTH-1:0]  m_last;

  cnt_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

  cnt_monitor #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .ERR_W(ERR_W), .RELOCK(RELOCK)) dut (
    .clk(gclk), .rst_n(rst_n), .bus(bus.slave)
  );

  initial gclk = 1'b0;
  always #10 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_run = 0; m_locked = 0; m_err = 0; m_pulse = 0;
    m_errc = '0; m_wrap = '0; m_last = '0;
  endtask

  task automatic m_step(input logic v, input logic [WIDTH-1:0] c, input logic cl);
    logic good;
    if (cl) begin
      m_reset();
      return;
    end
    m_pulse = 0;
    if (!v) return;
    good = (c == WIDTH'(m_last + 1));
    case (m_state)
      0: begin m_state = 1; m_locked = 1; end
      1: if (good) begin
           if (m_last == 4'hF) begin m_wrap++; m_pulse = 1; end
         end else begin
           m_err = 1; if (m_errc != 4'hF) m_errc++;
           m_run = 0; m_state = 2; m_locked = 0;
         end
      default: if (good) begin
           if (m_run + 1 == RELOCK) begin m_run = 0; m_state = 1; m_locked = 1; end
           else m_run++;
         end else begin
           if (m_errc != 4'hF) m_errc++;
           m_run = 0;
         end
    endcase
    m_last = c;
  endtask

  task automatic check_all(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_locked"}, bus.locked,     e.locked);
    chk({tag, "_err"},    bus.err,        e.err);
    chk({tag, "_errcnt"}, bus.err_cnt,    e.err_cnt);
    chk({tag, "_wrap"},   bus.wrap_cnt,   e.wrap_cnt);
    chk({tag, "_pulse"},  bus.wrap_pulse, e.wrap_pulse);
    chk({tag, "_last"},   bus.last_cnt,   e.last_cnt);
  endtask

  // Drive at the falling edge, model on the rising edge, compare at the next falling edge.
  task automatic cyc(input string tag, input logic v, input logic [WIDTH-1:0] c, input logic cl);
    exp_t e;
    bus.cnt_valid = v; bus.cnt = c; bus.clr = cl;
    @(posedge gclk);
    m_step(v, c, cl);
    e.locked = m_locked; e.err = m_err; e.wrap_pulse = m_pulse;
    e.err_cnt = m_errc; e.wrap_cnt = m_wrap; e.last_cnt = m_last;
    sb.push_back(e);
    @(negedge gclk);
    bus.cnt_valid = 1'b0; bus.clr = 1'b0;
    check_all(tag);
  endtask

  task automatic samp(input string tag, input int c);
    cyc(tag, 1'b1, WIDTH'(c), 1'b0);
  endtask

  task automatic do_clr();
    cyc("clr", 1'b0, '0, 1'b1);
  endtask

  initial begin
    m_reset();
    rst_n = 1'b0; bus.cnt_valid = 1'b0; bus.cnt = '0; bus.clr = 1'b0;
    #5 rst_n = 1'b1;
    @(negedge gclk);
    chk("rst_locked", bus.locked, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_errcnt", bus.err_cnt, 0);
    chk("rst_wrap", bus.wrap_cnt, 0);
    chk("rst_last", bus.last_cnt, 0);

    // full count with a wrap
    for (int i = 0; i < 18; i++) begin
      samp("wrapseq", i % 16);
      if (i == 1)  chk("lock_2nd", bus.locked, 1);
      if (i == 16) chk("pulse_hi", bus.wrap_pulse, 1);
      if (i == 17) chk("pulse_lo", bus.wrap_pulse, 0);
    end
    chk("wrap_one", bus.wrap_cnt, 1);
    chk("no_err", bus.err, 0);

    // single jump then relock
    do_clr();
    begin
      int s[6] = '{3, 4, 5, 7, 8, 9};
      foreach (s[i]) begin
        samp("jump", s[i]);
        if (i == 3) begin
          chk("jump_err", bus.err, 1);
          chk("jump_errcnt", bus.err_cnt, 1);
          chk("jump_unlock", bus.locked, 0);
        end
      end
    end
    chk("jump_relock", bus.locked, 1);
    chk("jump_wrap", bus.wrap_cnt, 0);

    // second error while resyncing
    do_clr();
    begin
      int s[8] = '{3, 4, 5, 7, 8, 2, 3, 4};
      foreach (s[i]) begin
        samp("resync", s[i]);
        if (i == 5) chk("resync_errcnt2", bus.err_cnt, 2);
        if (i == 6) chk("resync_still_unlocked", bus.locked, 0);
      end
    end
    chk("resync_relock", bus.locked, 1);

    // saturation with repeated values
    do_clr();
    samp("sat_ref", 0);
    for (int i = 0; i < 20; i++) samp("sat", 0);
    chk("sat_errcnt", bus.err_cnt, 15);
    chk("sat_err", bus.err, 1);
    chk("sat_unlock", bus.locked, 0);

    // gap in valid before the wrap
    do_clr();
    for (int i = 0; i < 15; i++) samp("gap_pre", i);
    for (int i = 0; i < 3; i++) begin
      cyc("gap", 1'b0, 4'h3, 1'b0);
      chk("gap_frozen_last", bus.last_cnt, 14);
    end
    samp("gap_15", 15);
    samp("gap_0", 0);
    chk("gap_wrap", bus.wrap_cnt, 1);
    chk("gap_noerr", bus.err, 0);

    // asynchronous reset mid-stream, then clr with a discarded sample
    do_clr();
    for (int i = 0; i < 10; i++) samp("mid", i);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_locked", bus.locked, 0);
    chk("mid_rst_last", bus.last_cnt, 0);
    chk("mid_rst_wrap", bus.wrap_cnt, 0);
    @(negedge gclk);
    rst_n = 1'b1;
    samp("post_rst", 10);
    chk("post_rst_lock", bus.locked, 1);
    samp("post_rst2", 11);
    cyc("clr_bad", 1'b1, 4'h6, 1'b1);
    chk("clr_errcnt", bus.err_cnt, 0);
    chk("clr_last", bus.last_cnt, 0);
    samp("after_clr", 9);
    chk("after_clr_lock", bus.locked, 1);
    chk("after_clr_err", bus.err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/cnt_monitor.md
Name: cnt_monitor

Overview:
- Downstream consumer of the free-running WIDTH-bit up-counter's `cnt` output.
- Checks every valid sample for a +1 mod 2^WIDTH step, counts wrap-arounds, and counts and flags sequence errors.
- Runs a lock/resync state machine so that a sample jump is reported once and tracking then recovers.
- Sits on the same `clk`/`rst_n` domain as the counter and feeds status to a display/debug stage.

Parameters:
- WIDTH, 4: width of the monitored count.
- WRAP_W, 8: width of the wrap counter; wraps modulo 2^WRAP_W.
- ERR_W, 4: width of the error counter; saturates.
- RELOCK, 2: consecutive correct steps in RESYNC needed to return to TRACK; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cnt_valid  input  1  cnt is a sample this cycle.
- cnt  input  WIDTH  counter value under test.
- clr  input  1  synchronous clear of all state and status.
- locked  output  1  high while in TRACK.
- err  output  1  sticky error flag.
- err_cnt  output  ERR_W  sequence errors seen, saturating at all-ones.
- wrap_cnt  output  WRAP_W  wraps seen in TRACK.
- wrap_pulse  output  1  one-cycle pulse per counted wrap.
- last_cnt  output  WIDTH  most recent accepted sample.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=SYNC.
  - locked=0, err=0, err_cnt=0, wrap_cnt=0, wrap_pulse=0, last_cnt=0, good-run counter=0.
- Outputs are all registered. Effect of a sample appears one clk after the edge that samples it.
- Priority per edge: rst_n > clr > cnt_valid.
- clr=1: same values as reset, applied synchronously. Any sample in that cycle is discarded.
- cnt_valid=0: all state held; wrap_pulse=0.
- "Step good" means cnt == last_cnt+1, computed in WIDTH bits. So 2^WIDTH-1 -> 0 is good.
- "Wrap" means step good AND last_cnt == 2^WIDTH-1.
- On every valid sample, last_cnt <= cnt.
- States:
  - SYNC: no reference value yet.
    - First valid sample is taken as reference; go to TRACK.
    - No check and no wrap counted on this sample.
  - TRACK (locked=1):
    - Good step: stay in TRACK. If wrap: wrap_cnt+1 and wrap_pulse=1 for one cycle.
    - Bad step: err<=1, err_cnt+1 (saturating), good-run counter=0, go to RESYNC. locked falls on the same edge.
  - RESYNC (locked=0):
    - Good step: good-run counter+1. On reaching RELOCK, go to TRACK with good-run counter=0.
    - Bad step: err_cnt+1 (saturating), good-run counter=0, stay in RESYNC.
    - Wraps are not counted in RESYNC.
- err stays 1 until reset or clr.
- err_cnt holds at 2^ERR_W-1 once saturated.
- wrap_cnt rolls over 2^WRAP_W-1 -> 0 silently.
- Repeated value (cnt == last_cnt) counts as a bad step.
- A reset pulse in mid-stream forces SYNC. The next sample re-references with no error.

Test Plan:
- Reset-release at 5 ns, clk period 20 ns, cnt_valid=1, stream 0,1,…,15,0,1 -> locked=1 after the 2nd sample; wrap_cnt=1 and wrap_pulse high for exactly one cycle after the 0 sample; err=0.
- Stream 3,4,5,7,8,9 with RELOCK=2 -> after sample 7: err=1, err_cnt=1, locked=0; after sample 9: locked=1; wrap_cnt=0.
- In RESYNC, stream 7,8,2,3,4 -> err_cnt increments to 2 on sample 2; locked returns only after sample 4.
- 20 consecutive bad samples with ERR_W=4 -> err_cnt=15 held; err=1; locked=0.
- cnt_valid low for 3 cycles between samples 14 and 15, then 15,0 -> no error; wrap_cnt=1; outputs frozen during the gap.
- Drive rst_n=0 mid-stream at sample 9, then clr=1 on a cycle with cnt_valid=1 and a bad value -> all outputs are 0 immediately on reset and again after clr; no error is counted for the clr-cycle sample; the next sample returns to TRACK.
